// File: rtl/pdm_pkg.sv
// pdm_pkg: shared defaults and arithmetic helpers for the PDM transmitter.
// Holds the default divider/oversampling/width constants, the integrator
// width rule and the signed saturation used by the modulator core.
package pdm_pkg;

  localparam int CLK_DIV_DEF   = 25;
  localparam int OSR_DEF       = 64;
  localparam int SAMPLE_W_DEF  = 16;
  localparam int ACC_GUARD_DEF = 4;

  // Integrators carry guard bits above the sample width so that the loop
  // has headroom before saturation kicks in.
  function automatic int acc_width(input int sample_w, input int guard);
    return sample_w + guard;
  endfunction

  // Clamp a wide signed value into the signed range of 'width' bits.
  // The result stays 64 bits wide; the caller keeps the low 'width' bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/pdm_tx_if.sv
// pdm_tx_if: valid/ready PCM sample stream feeding the PDM transmitter.
// The producer uses the master modport, pdm_tx uses the slave modport.
interface pdm_tx_if import pdm_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEF
);

  logic [SAMPLE_W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tready;

  modport master (output s_tdata, output s_tvalid, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, output s_tready);

endinterface

// File: rtl/pdm_tx_sdm2.sv
// pdm_sdm2: second-order sigma-delta modulator core.
// On every tick both saturating integrators advance with the feedback taken
// from the current output bit, and the new bit is the sign of I2.
module pdm_sdm2 import pdm_pkg::*; #(
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic signed [SAMPLE_W-1:0] x,
  output logic                       bit_out
);

  localparam int ACC_W = acc_width(SAMPLE_W, ACC_GUARD);
  localparam logic signed [63:0] FB_MAG = 64'sd1 <<< (SAMPLE_W - 1);

  logic signed [ACC_W-1:0] r_i1;
  logic signed [ACC_W-1:0] r_i2;
  logic signed [63:0]      w_fb;
  logic signed [63:0]      w_sum1;
  logic signed [63:0]      w_i1_next;
  logic signed [63:0]      w_sum2;
  logic signed [63:0]      w_i2_next;
  logic                    w_bit_next;

  // Loop arithmetic, done wide so the clamp sees the true overflowed sum.
  always_comb begin
    w_fb       = bit_out ? FB_MAG : -FB_MAG;
    w_sum1     = 64'(r_i1) + 64'(x) - w_fb;
    w_i1_next  = sat_signed(w_sum1, ACC_W);
    w_sum2     = 64'(r_i2) + w_i1_next - w_fb;
    w_i2_next  = sat_signed(w_sum2, ACC_W);
    w_bit_next = (w_i2_next >= 64'sd0);
  end

  // Integrators and output bit only move on a bit tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i1    <= '0;
      r_i2    <= '0;
      bit_out <= 1'b0;
    end else if (tick) begin
      r_i1    <= w_i1_next[ACC_W-1:0];
      r_i2    <= w_i2_next[ACC_W-1:0];
      bit_out <= w_bit_next;
    end
  end

endmodule

// File: rtl/pdm_tx.sv
// pdm_tx: 1-bit PDM transmitter. Generates M_CLK, zero-order-holds PCM
// samples for OSR bits each and drives a 2nd-order sigma-delta bitstream.
// Optional macro PDM_TX_UNDERRUN_CNT_EN adds a saturating underrun counter.
module pdm_tx import pdm_pkg::*; #(
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int OSR       = OSR_DEF,
  parameter int SAMPLE_W  = SAMPLE_W_DEF,
  parameter int ACC_GUARD = ACC_GUARD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  pdm_tx_if.slave     s,
  output logic        M_CLK,
  output logic        M_DATA,
  output logic        m_clk_rising,
  output logic        underrun
`ifdef PDM_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OSR_W = (OSR > 1) ? $clog2(OSR) : 1;

  logic [DIV_W-1:0]           r_div;
  logic                       r_mclk;
  logic                       r_rise;
  logic [OSR_W-1:0]           r_osr;
  logic [SAMPLE_W-1:0]        r_hold;
  logic                       r_hold_full;
  logic signed [SAMPLE_W-1:0] r_active;
  logic                       r_underrun;

  logic w_tc;
  logic w_tick;
  logic w_boundary;
  logic w_consume;
  logic w_xfer;
  logic w_underrun_set;

  // A bit tick is the enabled terminal count that takes M_CLK from 1 to 0.
  assign w_tc           = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_tick         = en && w_tc && r_mclk;
  assign w_boundary     = w_tick && (r_osr == OSR_W'(OSR - 1));
  assign w_consume      = w_boundary && r_hold_full;
  assign w_underrun_set = w_boundary && !r_hold_full;
  assign w_xfer         = s.s_tvalid && s.s_tready;

  assign s.s_tready   = !r_hold_full;
  assign M_CLK        = r_mclk;
  assign m_clk_rising = r_rise;
  assign underrun     = r_underrun;

  // Clock divider: M_CLK toggles every CLK_DIV enabled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      r_mclk <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_rise <= en && w_tc && !r_mclk;
      if (en) begin
        if (w_tc) begin
          r_div  <= '0;
          r_mclk <= !r_mclk;
        end else begin
          r_div <= r_div + DIV_W'(1);
        end
      end
    end
  end

  // OSR counter marks the sample boundary every OSR bit ticks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_osr <= '0;
    end else if (w_tick) begin
      r_osr <= (r_osr == OSR_W'(OSR - 1)) ? '0 : r_osr + OSR_W'(1);
    end
  end

  // Holding/active registers: consume at the boundary, then refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_active    <= '0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun  <= w_underrun_set;
      r_hold_full <= (r_hold_full && !w_consume) || w_xfer;
      if (w_consume) r_active <= r_hold;
      if (w_xfer)    r_hold   <= s.s_tdata;
    end
  end

`ifdef PDM_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  // Saturating underrun count, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun_set && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  pdm_sdm2 #(
    .SAMPLE_W  (SAMPLE_W),
    .ACC_GUARD (ACC_GUARD)
  ) u_sdm2 (
    .clk     (clk),
    .rst     (rst),
    .tick    (w_tick),
    .x       (r_active),
    .bit_out (M_DATA)
  );

endmodule

// File: tb/tb_pdm_tx.sv
// tb_pdm_tx: directed/randomized bench for pdm_tx with a behavioural model.
// Small divider/OSR values keep the density windows short; the model works
// from enabled-cycle counts and plain integer loop arithmetic.
// Honours PDM_TX_UNDERRUN_CNT_EN when defined.
module tb_pdm_tx;

  localparam int CD    = 2;
  localparam int OSR_P = 8;
  localparam int SW    = 16;
  localparam int AG    = 4;
  localparam int BITP  = 2 * CD;
  localparam longint FBM     = longint'(1) <<< (SW - 1);
  localparam longint ACC_MAX = (longint'(1) <<< (SW + AG - 1)) - 1;
  localparam longint ACC_MIN = -(longint'(1) <<< (SW + AG - 1));

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic M_CLK, M_DATA, m_clk_rising, underrun;
`ifdef PDM_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  pdm_tx_if #(.SAMPLE_W(SW)) bus ();

  pdm_tx #(
    .CLK_DIV   (CD),
    .OSR       (OSR_P),
    .SAMPLE_W  (SW),
    .ACC_GUARD (AG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .s            (bus),
    .M_CLK        (M_CLK),
    .M_DATA       (M_DATA),
    .m_clk_rising (m_clk_rising),
    .underrun     (underrun)
`ifdef PDM_TX_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Model state
  longint n, mI1, mI2;
  int     mBit, mActive, bitCount, mUcnt;
  logic [15:0] mHold;
  bit     mHoldFull, mUnder, mRise, mTick, mXfer;

  // Accumulators over observed DUT behaviour
  int onesAcc, risesAcc, underAcc, dutAccepts;
  int passCnt, totalCnt;

  function automatic longint msat(input longint v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  function automatic void modelReset();
    n = 0; mI1 = 0; mI2 = 0; mBit = 0; mActive = 0; bitCount = 0; mUcnt = 0;
    mHold = '0; mHoldFull = 1'b0; mUnder = 1'b0; mRise = 1'b0; mTick = 1'b0;
    mXfer = 1'b0;
  endfunction

  // One clock edge of the specified behaviour, given the pre-edge inputs.
  function automatic void modelStep(input bit r, input bit e, input bit v,
                                    input logic [15:0] d);
    longint fb;
    bit consume;
    if (!r) begin
      modelReset();
      return;
    end
    mXfer   = v && !mHoldFull;
    mUnder  = 1'b0;
    mRise   = 1'b0;
    mTick   = 1'b0;
    consume = 1'b0;
    if (e) begin
      n++;
      mRise = ((n % BITP) == CD);
      mTick = ((n % BITP) == 0);
    end
    if (mTick) begin
      fb  = (mBit != 0) ? FBM : -FBM;
      mI1 = msat(mI1 + mActive - fb);
      mI2 = msat(mI2 + mI1 - fb);
      mBit = (mI2 >= 0) ? 1 : 0;
      if ((bitCount % OSR_P) == OSR_P - 1) begin
        if (mHoldFull) begin
          mActive = int'($signed(mHold));
          consume = 1'b1;
        end else begin
          mUnder = 1'b1;
          if (mUcnt < 65535) mUcnt++;
        end
      end
      bitCount++;
    end
    mHoldFull = (mHoldFull && !consume) || mXfer;
    if (mXfer) mHold = d;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    totalCnt++;
    assert (obs === exp) passCnt++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic checkRange(input string tag, input int obs, input int lo,
                            input int hi);
    totalCnt++;
    assert (obs >= lo && obs <= hi) passCnt++;
    else $error("[TB] FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  // Drive inputs for 'cycles' clocks, advancing the model and checking
  // every output one time unit after each rising edge.
  task automatic applyStimulus(input bit r, input bit e, input bit v,
                               input logic [15:0] d, input int cycles,
                               input bit randomData);
    logic [15:0] dd;
    for (int c = 0; c < cycles; c++) begin
      dd = randomData ? 16'($urandom) : d;
      rst = r;
      en  = e;
      bus.s_tvalid = v;
      bus.s_tdata  = dd;
      #1;
      if (r && v && bus.s_tready) dutAccepts++;
      @(posedge clk);
      modelStep(r, e, v, dd);
      #1;
      checkOutput("mclk", M_CLK, 64'(mRise | ((n / CD) % 2 == 1)));
      checkOutput("rise", m_clk_rising, 64'(mRise));
      checkOutput("mdata", M_DATA, 64'(mBit));
      checkOutput("underrun", underrun, 64'(mUnder));
      checkOutput("ready", bus.s_tready, 64'(!mHoldFull));
`ifdef PDM_TX_UNDERRUN_CNT_EN
      checkOutput("ucnt", underrun_cnt, 64'(mUcnt));
`endif
      if (mTick && M_DATA === 1'b1) onesAcc++;
      if (m_clk_rising === 1'b1) risesAcc++;
      if (underrun === 1'b1) underAcc++;
    end
  endtask

  initial begin
    int waitCnt;
    passCnt = 0; totalCnt = 0;
    onesAcc = 0; risesAcc = 0; underAcc = 0; dutAccepts = 0;
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    modelReset();
    $display("[TB] start: CLK_DIV=%0d OSR=%0d", CD, OSR_P);

    // Reset held: everything zero, ready high
    applyStimulus(0, 0, 0, 16'h0, 4, 0);

    // Zero input stream; clock strobe count and density
    applyStimulus(1, 1, 1, 16'h0000, BITP * 16, 0);
    risesAcc = 0; onesAcc = 0;
    applyStimulus(1, 1, 1, 16'h0000, BITP * 64, 0);
    checkOutput("risesPer64", 64'(risesAcc), 64'd64);
    checkRange("zeroOnes64", onesAcc, 31, 33);

    // Enable low: no strobes, no underruns, state frozen
    risesAcc = 0; underAcc = 0;
    applyStimulus(1, 0, 1, 16'h0000, 23, 0);
    checkOutput("freezeRises", 64'(risesAcc), 64'd0);
    checkOutput("freezeUnder", 64'(underAcc), 64'd0);

    // DC +16384 -> density 0.75
    applyStimulus(1, 1, 1, 16'h4000, BITP * 64, 0);
    onesAcc = 0;
    applyStimulus(1, 1, 1, 16'h4000, BITP * 2048, 0);
    checkRange("dcPosOnes2048", onesAcc, 1516, 1556);

    // DC -16384 -> density 0.25
    applyStimulus(1, 1, 1, 16'hC000, BITP * 64, 0);
    onesAcc = 0;
    applyStimulus(1, 1, 1, 16'hC000, BITP * 2048, 0);
    checkRange("dcNegOnes2048", onesAcc, 492, 532);

    // Random samples, valid held: one acceptance per sample period
    dutAccepts = 0;
    applyStimulus(1, 1, 1, 16'h0, BITP * OSR_P * 16, 1);
    checkOutput("acceptsPer16", 64'(dutAccepts), 64'd16);

    // Underrun: last sample 0x1234, then valid drops
    waitCnt = 0;
    mXfer = 1'b0;
    while (!mXfer && waitCnt < BITP * OSR_P + 4) begin
      applyStimulus(1, 1, 1, 16'h1234, 1, 0);
      waitCnt++;
    end
    checkOutput("accept1234", 64'(mXfer), 64'd1);
    underAcc = 0;
    applyStimulus(1, 1, 0, 16'h0, BITP * OSR_P * 4, 0);
    checkOutput("underrunPulses", 64'(underAcc), 64'd3);
`ifdef PDM_TX_UNDERRUN_CNT_EN
    checkOutput("underrunCnt3", underrun_cnt, 64'd3);
`endif

    // Near full-scale input: loop stays stable, density above 0.99
    applyStimulus(1, 1, 1, 16'h7FFF, BITP * 64, 0);
    onesAcc = 0;
    applyStimulus(1, 1, 1, 16'h7FFF, BITP * 2000, 0);
    checkRange("satOnes2000", onesAcc, 1981, 2000);

    // Asynchronous reset mid-stream with a pending hold sample
    #2;
    rst = 1'b0;
    #1;
    modelReset();
    checkOutput("rstMclk", M_CLK, 64'd0);
    checkOutput("rstMdata", M_DATA, 64'd0);
    checkOutput("rstRise", m_clk_rising, 64'd0);
    checkOutput("rstUnder", underrun, 64'd0);
    checkOutput("rstReady", bus.s_tready, 64'd1);
    applyStimulus(0, 1, 1, 16'h7FFF, 3, 0);

    // After release with no data: first boundary after OSR bit ticks underruns
    underAcc = 0;
    applyStimulus(1, 1, 0, 16'h0, BITP * OSR_P + 8, 0);
    checkOutput("firstBoundaryUnder", 64'(underAcc), 64'd1);
`ifdef PDM_TX_UNDERRUN_CNT_EN
    checkOutput("underrunCntAfterRst", underrun_cnt, 64'd1);
`endif

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/pdm_tx.md
Name: pdm_tx

Overview:
- 1-bit PDM transmitter; the mirror of the PDM microphone receive path.
- Accepts signed PCM samples over a valid/ready stream and upsamples them by zero-order hold.
- A 2nd-order sigma-delta modulator turns the held sample into a PDM bitstream, driven with a locally generated PDM clock.
- Drives PDM amplifiers/DACs and provides loopback stimulus for the mic/CIC receive chain.

Parameters:
- CLK_DIV, 25, clk cycles per PDM-clock half period; must be >=1. The default gives 2 MHz M_CLK from 100 MHz clk.
- OSR, 64, PDM bits per PCM sample; must be >=2.
- SAMPLE_W, 16, PCM sample width, two's complement.
- ACC_GUARD, 4, extra integrator bits above SAMPLE_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- en  in  1  run enable; when 0, M_CLK, modulator and OSR counter freeze
- s_tdata  in  SAMPLE_W  PCM sample
- s_tvalid  in  1  sample valid
- s_tready  out  1  high when holding register is empty
- M_CLK  out  1  PDM clock, 50% duty
- M_DATA  out  1  PDM bitstream; changes on the M_CLK falling edge
- m_clk_rising  out  1  one-clk strobe in the cycle M_CLK goes 0->1
- underrun  out  1  one-clk pulse when a sample boundary finds the holding register empty
- underrun_cnt  out  16  (only with PDM_TX_UNDERRUN_CNT_EN) saturating underrun count

Behaviour:
- Reset (rst=0, async): M_CLK=0, M_DATA=0, m_clk_rising=0, underrun=0, underrun_cnt=0.
  - Divider, OSR counter and integrators are cleared.
  - Holding and active sample registers are 0; hold_full=0, so s_tready=1 after reset release.
- Divider: counter 0..CLK_DIV-1 advances when en=1. At terminal count it wraps and toggles M_CLK.
  - The toggle cycle 0->1 asserts m_clk_rising, registered and coincident with M_CLK going high.
  - The toggle cycle 1->0 is a "bit tick".
- Handshake: a transfer occurs when s_tvalid & s_tready at a clk edge. Data is latched into the holding register and hold_full sets.
  - s_tready = !hold_full, combinational from the flag.
  - Transfer and consumption in the same cycle: consumption first, then the new transfer refills; hold_full stays 1.
- OSR counter: 0..OSR-1, advanced on each bit tick. On a bit tick with the counter at OSR-1 (a sample boundary):
  - If hold_full=1: active <= hold, and hold_full clears.
  - Else: active keeps its value and underrun pulses for one clk.
- The first boundary after reset occurs OSR bit ticks after reset release. Until then active=0, i.e. idle pattern.
- Modulator, updated only on bit ticks, using x = active sample:
  - fb = +2^(SAMPLE_W-1) if M_DATA==1, else -2^(SAMPLE_W-1); fb uses the current M_DATA, before update.
  - I1' = sat(I1 + x - fb); I2' = sat(I2 + I1' - fb); M_DATA <= (I2' >= 0).
  - I1 and I2 are signed, SAMPLE_W+ACC_GUARD wide; sat clamps to the signed min/max of that width.
- The new M_DATA becomes visible on the same edge as the M_CLK 1->0 toggle. It is stable across the following rising edge, which gives CLK_DIV clk cycles of setup.
- x=0 yields an alternating 1010 pattern after settling. x=+max yields a ones density of ~(2^(SAMPLE_W-1)-1)/2^SAMPLE_W + 0.5.
- en=0: all state holds; no strobes and no underrun pulses. s_tready still reflects hold_full, so one sample can still be accepted.
- Reset mid-stream: immediate async clear. A pending hold sample is discarded.

Optional Feature:
- Macro PDM_TX_UNDERRUN_CNT_EN.
- Defined: the underrun_cnt port exists. It increments on each underrun pulse, saturates at 16'hFFFF, and clears only on reset.
- Undefined: the port and counter are absent; the underrun pulse is unchanged.

Decomposition:
- Package pdm_pkg: default CLK_DIV/OSR/SAMPLE_W/ACC_GUARD constants, a localparam function for ACC width, and the signed saturation helper function.
- Sub-module pdm_sdm2: the 2nd-order modulator core.
  - Ports: clk, rst, tick, x, bit_out.
- pdm_tx owns the divider, OSR counter, handshake and holding register.

Test Plan:
- Clock gen: CLK_DIV=25 -> M_CLK period 50 clk, high 25. m_clk_rising is exactly one pulse per period, coincident with M_CLK going 0->1. M_DATA never changes in a cycle where M_CLK rises.
- Zero input: stream 0x0000 continuously -> after 8 settling bits, M_DATA alternates 1,0,1,0; ones count over 64 bits is 32±1.
- DC levels: x=+16384 -> ones density over 4096 bits is 0.75±0.01. x=-16384 -> 0.25±0.01.
- Handshake: hold s_tvalid high with incrementing data -> exactly one acceptance per OSR bit ticks after the first fill. The sequence is loaded into active in order with none lost.
  - Back-to-back refill in the consumption cycle keeps s_tready=0.
- Underrun: stop s_tvalid after sample 0x1234 -> underrun pulses once per boundary and active stays 0x1234. With PDM_TX_UNDERRUN_CNT_EN, underrun_cnt counts 1,2,3.
- Saturation/reset: drive x=+32767 for 10000 bits -> integrators never wrap; M_DATA ones density >0.99. Assert rst mid-stream -> all outputs 0 immediately, s_tready=1 after release.
